// File: rtl/risc_toy_mem_stage.sv
// risc_toy_mem_stage: memory-access stage of the RISC_TOY five-stage pipeline.
//
// This stage holds the EX/MEM and MEM/WB pipeline registers. It issues one
// data-memory request per load or store and lines up the one-cycle-latency
// read data with its instruction in MEM/WB. When the pipeline is held, the
// load data is captured into a buffer so that it survives the freeze. The
// stage also exports forwarding and load-use information to the hazard unit.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   hold            global pipeline freeze (1 = all stage registers keep their values)
//   ex_*            instruction presented by the execute stage
//   mem_ready       ~hold; the execute stage advances only when this is 1
//   dreq/drw/daddr/dwdata/drdata
//                   data-memory port (word address, read data one cycle later)
//   wb_wen/wb_wa/wb_di
//                   register-file write port
//   fwd_xm_*, xm_is_load, fwd_mw_en
//                   hazard-unit forwarding and stall information
module risc_toy_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        ex_valid,
  input  logic [1:0]  ex_memop,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_stdata,
  input  logic        ex_wen,
  input  logic [4:0]  ex_wa,
  output logic        mem_ready,
  output logic        dreq,
  output logic        drw,
  output logic [29:0] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  output logic        wb_wen,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_di,
  output logic        fwd_xm_en,
  output logic [4:0]  fwd_xm_wa,
  output logic [31:0] fwd_xm_data,
  output logic        xm_is_load,
  output logic        fwd_mw_en
);

  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  // EX/MEM register
  logic        xm_v;
  logic [1:0]  xm_op;
  logic [31:0] xm_res;
  logic [31:0] xm_st;
  logic        xm_wen;
  logic [4:0]  xm_wa;

  // MEM/WB register
  logic        mw_v;
  logic        mw_ld;
  logic [31:0] mw_res;
  logic        mw_wen;
  logic [4:0]  mw_wa;

  // Load buffer: keeps read data alive while the pipeline is frozen
  logic        lb_v;
  logic [31:0] lb_data;

  logic xm_load;
  logic xm_store;

  assign xm_load  = xm_v && (xm_op == OpLoad);
  assign xm_store = xm_v && (xm_op == OpStore);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_v    <= 1'b0;
      xm_op   <= 2'b00;
      xm_res  <= 32'h0;
      xm_st   <= 32'h0;
      xm_wen  <= 1'b0;
      xm_wa   <= 5'd0;
      mw_v    <= 1'b0;
      mw_ld   <= 1'b0;
      mw_res  <= 32'h0;
      mw_wen  <= 1'b0;
      mw_wa   <= 5'd0;
      lb_v    <= 1'b0;
      lb_data <= 32'h0;
    end else if (!hold) begin
      xm_v    <= ex_valid;
      xm_op   <= ex_memop;
      xm_res  <= ex_result;
      xm_st   <= ex_stdata;
      // Stores never write the register file, whatever the decoder said.
      xm_wen  <= ex_wen && (ex_memop != OpStore);
      xm_wa   <= ex_wa;
      mw_v    <= xm_v;
      mw_ld   <= xm_load;
      mw_res  <= xm_res;
      mw_wen  <= xm_wen;
      mw_wa   <= xm_wa;
      lb_v    <= 1'b0;
    end else if (mw_ld && !lb_v) begin
      // Read data is only valid in the first MEM/WB cycle; later changes are ignored.
      lb_data <= drdata;
      lb_v    <= 1'b1;
    end
  end

  assign mem_ready = ~hold;

  // The request fires only in the cycle the instruction actually leaves EX/MEM,
  // so a hold in the request cycle defers it rather than duplicating it.
  assign dreq   = (xm_load || xm_store) && !hold;
  assign drw    = dreq && (xm_op == OpStore);
  assign daddr  = xm_res[31:2];
  assign dwdata = xm_st;

  assign wb_di  = mw_ld ? (lb_v ? lb_data : drdata) : mw_res;
  assign wb_wen = mw_v && mw_wen && !hold;
  assign wb_wa  = mw_wa;

  assign fwd_xm_en   = xm_v && xm_wen && (xm_op != OpLoad);
  assign fwd_xm_wa   = xm_wa;
  assign fwd_xm_data = xm_res;
  assign xm_is_load  = xm_load;
  assign fwd_mw_en   = mw_v && mw_wen;

endmodule

// File: tb/tb_risc_toy_mem_stage.sv
module tb_risc_toy_mem_stage;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        ex_valid;
  logic [1:0]  ex_memop;
  logic [31:0] ex_result;
  logic [31:0] ex_stdata;
  logic        ex_wen;
  logic [4:0]  ex_wa;
  logic        mem_ready;
  logic        dreq;
  logic        drw;
  logic [29:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        wb_wen;
  logic [4:0]  wb_wa;
  logic [31:0] wb_di;
  logic        fwd_xm_en;
  logic [4:0]  fwd_xm_wa;
  logic [31:0] fwd_xm_data;
  logic        xm_is_load;
  logic        fwd_mw_en;

  int n_chk;
  int n_fail;

  risc_toy_mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .ex_valid    (ex_valid),
    .ex_memop    (ex_memop),
    .ex_result   (ex_result),
    .ex_stdata   (ex_stdata),
    .ex_wen      (ex_wen),
    .ex_wa       (ex_wa),
    .mem_ready   (mem_ready),
    .dreq        (dreq),
    .drw         (drw),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .drdata      (drdata),
    .wb_wen      (wb_wen),
    .wb_wa       (wb_wa),
    .wb_di       (wb_di),
    .fwd_xm_en   (fwd_xm_en),
    .fwd_xm_wa   (fwd_xm_wa),
    .fwd_xm_data (fwd_xm_data),
    .xm_is_load  (xm_is_load),
    .fwd_mw_en   (fwd_mw_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per cycle: inputs driven for that cycle and the outputs expected
  // during that cycle (before the next rising edge).
  typedef struct {
    logic        hold;
    logic        ev;
    logic [1:0]  op;
    logic [31:0] res;
    logic [31:0] st;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] drd;
    logic        e_dreq;
    logic        e_drw;
    logic [29:0] e_daddr;
    logic [31:0] e_dwdata;
    logic        e_wbwen;
    logic [4:0]  e_wbwa;
    logic [31:0] e_wbdi;
    logic        e_fxen;
    logic [4:0]  e_fxwa;
    logic [31:0] e_fxdata;
    logic        e_isld;
    logic        e_fmwen;
  } vec_t;

  localparam int NumVec = 22;
  vec_t vecs [NumVec];

  function automatic vec_t mk(
    logic h, logic ev, logic [1:0] op, logic [31:0] res, logic [31:0] st, logic wen,
    logic [4:0] wa, logic [31:0] drd,
    logic dq, logic rw, logic [29:0] da, logic [31:0] dw,
    logic ww, logic [4:0] wwa, logic [31:0] wdi,
    logic fx, logic [4:0] fxa, logic [31:0] fxd, logic ld, logic fm);
    vec_t v;
    v.hold = h;  v.ev = ev;  v.op = op;  v.res = res;  v.st = st;
    v.wen = wen; v.wa = wa;  v.drd = drd;
    v.e_dreq = dq;   v.e_drw = rw;    v.e_daddr = da;  v.e_dwdata = dw;
    v.e_wbwen = ww;  v.e_wbwa = wwa;  v.e_wbdi = wdi;
    v.e_fxen = fx;   v.e_fxwa = fxa;  v.e_fxdata = fxd;
    v.e_isld = ld;   v.e_fmwen = fm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    hold      = 1'b0;
    ex_valid  = 1'b0;
    ex_memop  = 2'b00;
    ex_result = 32'h0;
    ex_stdata = 32'h0;
    ex_wen    = 1'b0;
    ex_wa     = 5'd0;
    drdata    = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".dreq"},   {31'h0, dreq},       32'h0);
    chk({tag, ".drw"},    {31'h0, drw},        32'h0);
    chk({tag, ".wb_wen"}, {31'h0, wb_wen},     32'h0);
    chk({tag, ".fxen"},   {31'h0, fwd_xm_en},  32'h0);
    chk({tag, ".isld"},   {31'h0, xm_is_load}, 32'h0);
    chk({tag, ".fmwen"},  {31'h0, fwd_mw_en},  32'h0);
    chk({tag, ".wb_di"},  wb_di,               32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Vector table: columns are
    // hold ev op res st wen wa drd | dreq drw daddr dwdata | wbwen wbwa wbdi | fxen fxwa fxdata isld fmwen
    vecs[0]  = mk(0,1,2'b10,32'h104,32'hDEADBEEF,1,9,0,  0,0,30'h0,32'h0,  0,0,32'h0,  0,0,32'h0,0,0);
    vecs[1]  = mk(0,0,2'b00,0,0,0,0,0,  1,1,30'h41,32'hDEADBEEF,  0,0,32'h0,  0,9,32'h104,0,0);
    vecs[2]  = mk(0,1,2'b01,32'h200,0,1,7,0,  0,0,30'h0,32'h0,  0,9,32'h104,  0,0,32'h0,0,0);
    vecs[3]  = mk(0,0,2'b00,0,0,0,0,0,  1,0,30'h80,32'h0,  0,0,32'h0,  0,7,32'h200,1,0);
    vecs[4]  = mk(0,1,2'b00,32'h55,0,1,3,32'h12345678,  0,0,30'h0,32'h0,
                  1,7,32'h12345678,  0,0,32'h0,0,1);
    vecs[5]  = mk(0,1,2'b01,32'h300,0,1,4,0,  0,0,30'h15,32'h0,  0,0,32'h0,  1,3,32'h55,0,0);
    vecs[6]  = mk(0,0,2'b00,0,0,0,0,0,  1,0,30'hC0,32'h0,  1,3,32'h55,  0,4,32'h300,1,1);
    // Load r4 in MEM/WB, held for three cycles with changing read data
    vecs[7]  = mk(1,0,2'b00,0,0,0,0,32'hAAAA0001,  0,0,30'h0,32'h0,
                  0,4,32'hAAAA0001,  0,0,32'h0,0,1);
    vecs[8]  = mk(1,0,2'b00,0,0,0,0,32'hBBBB0002,  0,0,30'h0,32'h0,
                  0,4,32'hAAAA0001,  0,0,32'h0,0,1);
    vecs[9]  = mk(1,0,2'b00,0,0,0,0,32'hCCCC0003,  0,0,30'h0,32'h0,
                  0,4,32'hAAAA0001,  0,0,32'h0,0,1);
    vecs[10] = mk(0,0,2'b00,0,0,0,0,32'hDDDD0004,  0,0,30'h0,32'h0,
                  1,4,32'hAAAA0001,  0,0,32'h0,0,1);
    vecs[11] = mk(0,0,2'b00,0,0,0,0,0,  0,0,30'h0,32'h0,  0,0,32'h0,  0,0,32'h0,0,0);
    // Hold in a load's request cycle; held EX inputs must be ignored
    vecs[12] = mk(0,1,2'b01,32'h44,0,1,5,0,  0,0,30'h0,32'h0,  0,0,32'h0,  0,0,32'h0,0,0);
    vecs[13] = mk(1,1,2'b10,32'h888,32'h1111,0,1,0,  0,0,30'h11,32'h0,
                  0,0,32'h0,  0,5,32'h44,1,0);
    vecs[14] = mk(1,1,2'b10,32'h888,32'h1111,0,1,0,  0,0,30'h11,32'h0,
                  0,0,32'h0,  0,5,32'h44,1,0);
    vecs[15] = mk(0,0,2'b00,0,0,0,0,0,  1,0,30'h11,32'h0,  0,0,32'h0,  0,5,32'h44,1,0);
    vecs[16] = mk(0,0,2'b00,0,0,0,0,32'h0F0F0F0F,  0,0,30'h0,32'h0,
                  1,5,32'h0F0F0F0F,  0,0,32'h0,0,1);
    // Back-to-back load then store
    vecs[17] = mk(0,1,2'b01,32'h10,0,1,6,0,  0,0,30'h0,32'h0,  0,0,32'h0,  0,0,32'h0,0,0);
    vecs[18] = mk(0,1,2'b10,32'h20,32'h5A5A5A5A,1,2,0,  1,0,30'h4,32'h0,
                  0,0,32'h0,  0,6,32'h10,1,0);
    vecs[19] = mk(0,0,2'b00,0,0,0,0,32'h600DF00D,  1,1,30'h8,32'h5A5A5A5A,
                  1,6,32'h600DF00D,  0,2,32'h20,0,1);
    vecs[20] = mk(0,0,2'b00,0,0,0,0,0,  0,0,30'h0,32'h0,  0,2,32'h20,  0,0,32'h0,0,0);
    vecs[21] = mk(0,0,2'b00,0,0,0,0,0,  0,0,30'h0,32'h0,  0,0,32'h0,  0,0,32'h0,0,0);

    // Reset state
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.mem_ready", {31'h0, mem_ready}, 32'h1);
    check_all_zero("rst");
    chk("rst.daddr", {2'b00, daddr}, 32'h0);

    // Reset with a store pending in EX/MEM
    @(negedge clk);
    rst       = 1'b0;
    ex_valid  = 1'b1;
    ex_memop  = 2'b10;
    ex_result = 32'h104;
    ex_stdata = 32'hCAFEF00D;
    ex_wen    = 1'b1;
    ex_wa     = 5'd9;
    @(negedge clk);
    drive_idle();
    #1;
    chk("pend.dreq", {31'h0, dreq}, 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    #1;
    check_all_zero("rst_held");
    rst = 1'b0;
    #1;
    check_all_zero("rst_rel");
    @(negedge clk);
    #1;
    check_all_zero("rst_after");

    // Table-driven main sequence
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      hold      = vecs[i].hold;
      ex_valid  = vecs[i].ev;
      ex_memop  = vecs[i].op;
      ex_result = vecs[i].res;
      ex_stdata = vecs[i].st;
      ex_wen    = vecs[i].wen;
      ex_wa     = vecs[i].wa;
      drdata    = vecs[i].drd;
      #1;
      chk($sformatf("v%0d.mem_ready", i), {31'h0, mem_ready}, {31'h0, ~vecs[i].hold});
      chk($sformatf("v%0d.dreq", i),      {31'h0, dreq},       {31'h0, vecs[i].e_dreq});
      chk($sformatf("v%0d.drw", i),       {31'h0, drw},        {31'h0, vecs[i].e_drw});
      chk($sformatf("v%0d.daddr", i),     {2'b00, daddr},      {2'b00, vecs[i].e_daddr});
      chk($sformatf("v%0d.dwdata", i),    dwdata,              vecs[i].e_dwdata);
      chk($sformatf("v%0d.wb_wen", i),    {31'h0, wb_wen},     {31'h0, vecs[i].e_wbwen});
      chk($sformatf("v%0d.wb_wa", i),     {27'h0, wb_wa},      {27'h0, vecs[i].e_wbwa});
      chk($sformatf("v%0d.wb_di", i),     wb_di,               vecs[i].e_wbdi);
      chk($sformatf("v%0d.fwd_xm_en", i), {31'h0, fwd_xm_en},  {31'h0, vecs[i].e_fxen});
      chk($sformatf("v%0d.fwd_xm_wa", i), {27'h0, fwd_xm_wa},  {27'h0, vecs[i].e_fxwa});
      chk($sformatf("v%0d.fwd_xm_data", i), fwd_xm_data,       vecs[i].e_fxdata);
      chk($sformatf("v%0d.xm_is_load", i), {31'h0, xm_is_load}, {31'h0, vecs[i].e_isld});
      chk($sformatf("v%0d.fwd_mw_en", i), {31'h0, fwd_mw_en},  {31'h0, vecs[i].e_fmwen});
    end

    // Reset in a load's request cycle; the read data arriving afterwards is ignored
    @(negedge clk);
    drive_idle();
    ex_valid  = 1'b1;
    ex_memop  = 2'b01;
    ex_result = 32'h40;
    ex_wen    = 1'b1;
    ex_wa     = 5'd8;
    @(negedge clk);
    drive_idle();
    #1;
    chk("mid.dreq", {31'h0, dreq}, 32'h1);
    chk("mid.isld", {31'h0, xm_is_load}, 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst    = 1'b0;
    drdata = 32'h77777777;
    #1;
    check_all_zero("mid_after");
    @(negedge clk);
    #1;
    check_all_zero("mid_later");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
